// File: rtl/masking_pkg.sv
// Shared types for the masked datapath: default share word, operating modes, and the
// two-state occupancy FSM used by streaming share blocks.
package masking_pkg;

    localparam int SHARE_W = 256;

    typedef logic [SHARE_W-1:0] share_t;

    typedef enum logic {
        MODE_MASK    = 1'b0,
        MODE_REFRESH = 1'b1
    } mode_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/share_refresh_comb.sv
// Pure combinational Boolean share refresh: q[0] = s[0] ^ (XOR of all masks),
// q[k] = s[k] ^ m[k-1]. The XOR of q always equals the XOR of s.
module share_refresh_comb #(
    parameter int SHARES = 3,
    parameter int WIDTH  = 256
) (
    input  logic [WIDTH-1:0]              s [SHARES],
    input  logic [(SHARES-1)*WIDTH-1:0]   m,
    output logic [WIDTH-1:0]              q [SHARES]
);

    logic [WIDTH-1:0] r;

    always_comb begin
        r = '0;
        for (int i = 0; i < SHARES - 1; i++) begin
            r = r ^ m[i*WIDTH +: WIDTH];
        end
        q[0] = s[0] ^ r;
        for (int k = 1; k < SHARES; k++) begin
            q[k] = s[k] ^ m[(k-1)*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/share_masker_stream.sv
// Registered SHARES-way Boolean masking/refresh stage with valid/ready on input, RNG and output.
// Build option SHARE_SCRUB_EN clears the share register when it drains without a refill.
module share_masker_stream
    import masking_pkg::*;
#(
    parameter int SHARES = 3,
    parameter int WIDTH  = 256,
    parameter int CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_refresh,
    input  logic [WIDTH-1:0]              in_data,
    input  logic [WIDTH-1:0]              in_shares [SHARES],
    input  logic                          rnd_valid,
    output logic                          rnd_ready,
    input  logic [(SHARES-1)*WIDTH-1:0]   rnd_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_shares [SHARES],
    output logic [CNT_W-1:0]              starve_cnt
);

    // Handshake: a transfer happens on a port in any cycle where its valid and ready are
    // both high at the rising edge. Input and randomness transfer together (fire) or not at
    // all; ready never depends on the same port's valid, only on the partner stream and slot.

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    mode_t            mode;
    logic             slot_avail;
    logic             fire;
    logic             starve;
    logic [WIDTH-1:0] s [SHARES];
    logic [WIDTH-1:0] q [SHARES];

    assign slot_avail = !out_valid || out_ready;
    assign fire       = in_valid && rnd_valid && slot_avail && !rst;
    assign starve     = in_valid && !rnd_valid && slot_avail && !rst;
    assign in_ready   = rnd_valid && slot_avail && !rst;
    assign rnd_ready  = in_valid && slot_avail && !rst;
    assign mode       = in_refresh ? MODE_REFRESH : MODE_MASK;

    // MASK places the plaintext in share 0 with zeros elsewhere, so the refresh gadget
    // produces a fresh sharing of it.
    always_comb begin
        for (int k = 0; k < SHARES; k++) begin
            s[k] = '0;
        end
        if (mode == MODE_REFRESH) begin
            for (int k = 0; k < SHARES; k++) begin
                s[k] = in_shares[k];
            end
        end else begin
            s[0] = in_data;
        end
    end

    share_refresh_comb #(
        .SHARES (SHARES),
        .WIDTH  (WIDTH)
    ) u_refresh (
        .s (s),
        .m (rnd_data),
        .q (q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (fire) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !fire) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_FULL);
    end

    // Held shares stay frozen while stalled; only a fire (or a scrubbing drain) changes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SHARES; k++) begin
                out_shares[k] <= '0;
            end
        end else if (fire) begin
            for (int k = 0; k < SHARES; k++) begin
                out_shares[k] <= q[k];
            end
        end
`ifdef SHARE_SCRUB_EN
        else if (out_valid && out_ready) begin
            for (int k = 0; k < SHARES; k++) begin
                out_shares[k] <= '0;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (starve && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_share_masker_stream.sv
// Bench for share_masker_stream (SHARES=3, WIDTH=8, CNT_W=4); expectations follow the
// SHARE_SCRUB_EN define so the same file covers both builds.
module tb_share_masker_stream;

    localparam int SHARES = 3;
    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;

    logic                        clk;
    logic                        rst;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_refresh;
    logic [WIDTH-1:0]            in_data;
    logic [WIDTH-1:0]            in_shares [SHARES];
    logic                        rnd_valid;
    logic                        rnd_ready;
    logic [(SHARES-1)*WIDTH-1:0] rnd_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [WIDTH-1:0]            out_shares [SHARES];
    logic [CNT_W-1:0]            starve_cnt;

    int errors;
    int checks;
    int fires;

    // Reference state: what the output slot should hold, as seen from outside.
    logic        exp_valid;
    logic [23:0] exp_sh;     // {share0, share1, share2}
    logic [7:0]  exp_plain;  // value the held shares must recombine to
    int          exp_cnt;

    share_masker_stream #(
        .SHARES (SHARES),
        .WIDTH  (WIDTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_refresh (in_refresh),
        .in_data    (in_data),
        .in_shares  (in_shares),
        .rnd_valid  (rnd_valid),
        .rnd_ready  (rnd_ready),
        .rnd_data   (rnd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares),
        .starve_cnt (starve_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    // Fresh sharing from first principles: masks m0,m1 go to shares 1,2 and share 0
    // absorbs both so the recombined value is unchanged.
    function automatic logic [23:0] ref_share(logic refresh, logic [7:0] d,
                                              logic [23:0] sh, logic [15:0] rnd);
        logic [7:0] s0, s1, s2, m0, m1;
        s0 = refresh ? sh[23:16] : d;
        s1 = refresh ? sh[15:8]  : 8'h00;
        s2 = refresh ? sh[7:0]   : 8'h00;
        m0 = rnd[7:0];
        m1 = rnd[15:8];
        return {s0 ^ m0 ^ m1, s1 ^ m0, s2 ^ m1};
    endfunction

    function automatic logic [23:0] out_vec();
        return {out_shares[0], out_shares[1], out_shares[2]};
    endfunction

    // ---------------- driver ----------------
    task automatic set_in(logic v, logic refresh, logic [7:0] d, logic [23:0] sh);
        in_valid     = v;
        in_refresh   = refresh;
        in_data      = d;
        in_shares[0] = sh[23:16];
        in_shares[1] = sh[15:8];
        in_shares[2] = sh[7:0];
    endtask

    task automatic set_rnd(logic v, logic [15:0] r);
        rnd_valid = v;
        rnd_data  = r;
    endtask

    // One clock: check readies for the inputs currently driven, advance the reference, check outputs.
    task automatic cycle();
        logic        slot, f, st;
        logic [23:0] nxt;
        logic [7:0]  plain;
        #1;
        slot  = !exp_valid || out_ready;
        f     = in_valid && rnd_valid && slot && !rst;
        st    = in_valid && !rnd_valid && slot && !rst;
        nxt   = ref_share(in_refresh, in_data,
                          {in_shares[0], in_shares[1], in_shares[2]}, rnd_data);
        plain = in_refresh ? (in_shares[0] ^ in_shares[1] ^ in_shares[2]) : in_data;
        chk("in_ready",  {31'd0, in_ready},  {31'd0, (rnd_valid && slot && !rst)});
        chk("rnd_ready", {31'd0, rnd_ready}, {31'd0, (in_valid && slot && !rst)});
        @(posedge clk);
        #1;
        if (rst) begin
            exp_valid = 1'b0;
            exp_sh    = '0;
            exp_cnt   = 0;
        end else begin
            if (f) begin
                fires++;
                exp_valid = 1'b1;
                exp_sh    = nxt;
                exp_plain = plain;
            end else if (exp_valid && out_ready) begin
                exp_valid = 1'b0;
`ifdef SHARE_SCRUB_EN
                exp_sh = '0;
`endif
            end
            if (st && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
        chk("out_valid",  {31'd0, out_valid}, {31'd0, exp_valid});
        chk("out_shares", {8'd0, out_vec()},  {8'd0, exp_sh});
        chk("starve_cnt", {28'd0, starve_cnt}, exp_cnt);
        if (exp_valid)
            chk("share_xor", {24'd0, out_shares[0] ^ out_shares[1] ^ out_shares[2]},
                {24'd0, exp_plain});
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [23:0] held;
        errors    = 0;
        checks    = 0;
        fires     = 0;
        exp_valid = 1'b0;
        exp_sh    = '0;
        exp_plain = '0;
        exp_cnt   = 0;
        out_ready = 1'b1;
        set_in(1'b1, 1'b0, 8'h5A, 24'h010203);
        set_rnd(1'b1, 16'hFFFF);

        // Reset with all valids asserted: nothing may transfer.
        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_shares", {8'd0, out_vec()}, 32'd0);
        rst = 1'b0;

        // MASK example vector.
        set_in(1'b1, 1'b0, 8'hA5, 24'hFFFFFF);
        set_rnd(1'b1, 16'h0F3C);
        cycle();
        chk("mask_vec", {8'd0, out_vec()}, 32'h00963C0F);

        // REFRESH example vector.
        set_in(1'b1, 1'b1, 8'hEE, 24'h112244);
        set_rnd(1'b1, 16'h8001);
        cycle();
        chk("refresh_vec", {8'd0, out_vec()}, 32'h009023C4);
        chk("refresh_xor", {24'd0, out_shares[0] ^ out_shares[1] ^ out_shares[2]}, 32'h77);

        // Backpressure: slot full and stalled for 5 cycles, shares frozen.
        set_in(1'b1, 1'b0, 8'h3E, 24'h0);
        set_rnd(1'b1, 16'h1234);
        out_ready = 1'b0;
        cycle();
        held = out_vec();
        set_in(1'b1, 1'b0, 8'h77, 24'h0);
        set_rnd(1'b1, 16'hBEEF);
        repeat (5) begin
            cycle();
            chk("stall_hold", {8'd0, out_vec()}, {8'd0, held});
        end
        // Release: four words back to back, each drained and refilled in one cycle.
        out_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, i[0], 8'(8'h10 * i + 3), 24'(24'h102030 * (i + 1)));
            set_rnd(1'b1, 16'(16'h1111 * (i + 1)));
            cycle();
        end
        chk("burst_fires", fires, 32'd4);

        // Drain, then starve the block of randomness.
        set_in(1'b0, 1'b0, 8'h00, 24'h0);
        cycle();
        set_in(1'b1, 1'b0, 8'hC3, 24'h0);
        set_rnd(1'b0, 16'hAAAA);
        repeat (10) cycle();
        chk("starve_10", {28'd0, starve_cnt}, 32'd10);
        repeat (20) cycle();
        chk("starve_sat", {28'd0, starve_cnt}, 32'd15);
        chk("starve_nofire", {31'd0, out_valid}, 32'd0);

        // Fill then drain with no refill: scrub build clears, default build retains.
        set_rnd(1'b1, 16'h5555);
        cycle();
        held = out_vec();
        set_in(1'b0, 1'b0, 8'h00, 24'h0);
        cycle();
`ifdef SHARE_SCRUB_EN
        chk("drain_scrub", {8'd0, out_vec()}, 32'd0);
`else
        chk("drain_keep", {8'd0, out_vec()}, {8'd0, held});
`endif

        // Reset while holding a stalled word: it must be discarded.
        set_in(1'b1, 1'b0, 8'h99, 24'h0);
        cycle();
        out_ready = 1'b0;
        rst = 1'b1;
        cycle();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        // Random traffic on all three streams.
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   8'($urandom), 24'($urandom));
            set_rnd(1'($urandom_range(0, 4) != 0), 16'($urandom));
            out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
